// File: rtl/snn_spi_cfg_ctrl.sv
// snn_spi_cfg_ctrl
//   SPI mode-0 slave that turns 16-bit {rw, addr, data} frames (MSB first) into
//   single-cycle configuration writes for the SNN core. A write is held pending
//   while the core is mid-timestep (snn_busy) and is issued on the first idle cycle.
//
// Optional feature macro: SNN_CFG_READBACK_EN
//   When defined, rw=1 frames issue cfg_re after the address byte and shift the
//   returned byte out on spi_cipo. Address 7'h7F reads back {7'b0, overrun}.
//   When undefined, rw=1 frames are consumed and discarded, and cfg_re,
//   spi_cipo and spi_cipo_oe are tied low.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   spi_sck         SPI clock, asynchronous to clk; must be <= clk/8
//   spi_cs_n        SPI chip select, active low
//   spi_copi        SPI data in
//   spi_cipo        SPI data out (read-back only)
//   spi_cipo_oe     spi_cipo drive enable (read-back only)
//   snn_busy        core mid-timestep; writes stall while high
//   cfg_we          one-cycle write strobe
//   cfg_re          one-cycle read strobe (read-back only)
//   cfg_addr        config address, valid with cfg_we / cfg_re
//   cfg_wdata       config write data, valid with cfg_we
//   cfg_rdata       config read data, valid the cycle after cfg_re
//   overrun         sticky: SCK rise dropped while a write was pending
module snn_spi_cfg_ctrl #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_copi,
  output logic              spi_cipo,
  output logic              spi_cipo_oe,
  input  logic              snn_busy,
  output logic              cfg_we,
  output logic              cfg_re,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_wdata,
  input  logic [DATA_W-1:0] cfg_rdata,
  output logic              overrun
);

  localparam int unsigned FW    = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(FW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT,
    S_WAIT_CS
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sck_sync;
  logic [SYNC_STAGES-1:0]  r_cs_sync;
  logic [SYNC_STAGES-1:0]  r_copi_sync;
  logic                    r_sck_prev;
  logic [FW-1:0]           r_shift;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_cfg_we;
  logic [ADDR_W-1:0]       r_cfg_addr;
  logic [DATA_W-1:0]       r_cfg_wdata;
  logic                    r_overrun;

  logic                    w_sck;
  logic                    w_cs_n;
  logic                    w_copi;
  logic                    w_sck_rise;
  logic                    w_sck_fall;
  logic [FW-1:0]           w_shift_nxt;
  logic                    w_last_bit;
  logic                    w_addr_all1;

  // Pad synchronisers; chip select resets high so reset release never looks like a frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_copi_sync <= '0;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi_copi};
      r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_sck_rise  = w_sck & ~r_sck_prev;
  assign w_sck_fall  = ~w_sck & r_sck_prev;
  assign w_shift_nxt = {r_shift[FW-2:0], w_copi};
  assign w_last_bit  = (r_bit_cnt == CNT_W'(FW - 1));
  assign w_addr_all1 = (r_cfg_addr == {ADDR_W{1'b1}});

`ifdef SNN_CFG_READBACK_EN
  logic r_cfg_re;
`endif

  // Frame FSM: shift, then hold the decoded write until the core is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_cfg_we    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_wdata <= '0;
      r_overrun   <= 1'b0;
`ifdef SNN_CFG_READBACK_EN
      r_cfg_re    <= 1'b0;
`endif
    end else begin
      r_cfg_we <= 1'b0;
`ifdef SNN_CFG_READBACK_EN
      r_cfg_re <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!w_cs_n) begin
            r_state   <= S_SHIFT;
            r_shift   <= '0;
            r_bit_cnt <= '0;
          end
        end

        S_SHIFT: begin
          if (w_cs_n) begin
            // Short frame: drop it silently
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
          end else if (w_sck_rise) begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`ifdef SNN_CFG_READBACK_EN
            // rw+addr complete: launch the read so data is ready before the data phase
            if ((r_bit_cnt == CNT_W'(ADDR_W)) && w_shift_nxt[ADDR_W]) begin
              r_cfg_re   <= 1'b1;
              r_cfg_addr <= w_shift_nxt[ADDR_W-1:0];
            end
`endif
            if (w_last_bit) begin
              if (w_shift_nxt[FW-1]) begin
                r_state <= S_WAIT_CS;
              end else begin
                r_state     <= S_COMMIT;
                r_cfg_addr  <= w_shift_nxt[FW-2 -: ADDR_W];
                r_cfg_wdata <= w_shift_nxt[DATA_W-1:0];
              end
            end
          end
        end

        S_COMMIT: begin
          // Only rises carry data; the fall trailing the last bit is expected here
          if (w_sck_rise) begin
            r_overrun <= 1'b1;
          end
          if (r_cfg_we) begin
            r_state <= w_cs_n ? S_IDLE : S_WAIT_CS;
          end else if (!snn_busy) begin
            r_cfg_we <= 1'b1;
            if (w_addr_all1) begin
              r_overrun <= 1'b0;
            end
          end
        end

        S_WAIT_CS: begin
          if (w_cs_n) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_we    = r_cfg_we;
  assign cfg_addr  = r_cfg_addr;
  assign cfg_wdata = r_cfg_wdata;
  assign overrun   = r_overrun;

`ifdef SNN_CFG_READBACK_EN
  logic              r_re_d;
  logic [DATA_W-1:0] r_rd_shift;
  logic              r_cipo;
  logic              r_cipo_oe;
  logic [DATA_W-1:0] w_rd_src;

  assign w_rd_src = w_addr_all1 ? DATA_W'(r_overrun) : cfg_rdata;

  // Read-back shifter: bit 7 is loaded before the 9th rise, later bits advance on sck falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_re_d     <= 1'b0;
      r_rd_shift <= '0;
      r_cipo     <= 1'b0;
      r_cipo_oe  <= 1'b0;
    end else begin
      r_re_d <= r_cfg_re;
      if (w_cs_n) begin
        r_cipo_oe <= 1'b0;
        r_cipo    <= 1'b0;
      end else begin
        if ((r_state == S_SHIFT) && w_sck_rise && (r_bit_cnt == '0) && w_copi) begin
          r_cipo_oe <= 1'b1;
        end
        if (r_re_d) begin
          r_rd_shift <= w_rd_src;
          r_cipo     <= w_rd_src[DATA_W-1];
        end else if (r_cipo_oe && (r_state == S_SHIFT) && w_sck_fall &&
                     (r_bit_cnt >= CNT_W'(ADDR_W + 2))) begin
          // The fall right after the 8th rise must keep bit 7 on the line
          r_rd_shift <= {r_rd_shift[DATA_W-2:0], 1'b0};
          r_cipo     <= r_rd_shift[DATA_W-2];
        end
      end
    end
  end

  assign cfg_re      = r_cfg_re;
  assign spi_cipo    = r_cipo;
  assign spi_cipo_oe = r_cipo_oe;
`else
  logic w_unused_rb;

  assign w_unused_rb = ^{cfg_rdata, w_sck_fall};
  assign cfg_re      = 1'b0;
  assign spi_cipo    = 1'b0;
  assign spi_cipo_oe = 1'b0;
`endif

endmodule
